ps2_movement_decoder: RTL and testbench

Upstream stage of player_updater. Receives the raw PS/2 keyboard serial stream, deserializes the scan-code frames, and tracks make/break (E0/F0) prefixes. Maintains four level "key held" flags that drive player_updater's turn_right/turn_left/move_forward/move_backward inputs directly. Arrow keys and WASD both map to the same four flags.

---
 rtl/ps2_movement_decoder_pkg.sv | 53 +++++
 rtl/ps2_movement_decoder_rx.sv | 123 ++++++++++++
 rtl/ps2_movement_decoder.sv | 82 ++++++++
 tb/tb_ps2_movement_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_movement_decoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_movement_decoder_pkg: scan codes, receiver states, key lookup |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package ps2_movement_decoder_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_OVR0    = 8'h00;
  localparam logic [7:0] SC_OVR1    = 8'hFF;
  localparam logic [7:0] SC_RIGHT_E = 8'h74;
  localparam logic [7:0] SC_LEFT_E  = 8'h6B;
  localparam logic [7:0] SC_FWD_E   = 8'h75;
  localparam logic [7:0] SC_BACK_E  = 8'h72;
  localparam logic [7:0] SC_RIGHT   = 8'h23;
  localparam logic [7:0] SC_LEFT    = 8'h1C;
  localparam logic [7:0] SC_FWD     = 8'h1D;
  localparam logic [7:0] SC_BACK    = 8'h1B;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Returns {hit, index}; index 3=right, 2=left, 1=forward, 0=backward.
  function automatic logic [2:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [2:0] res;
    res = 3'b000;
    if (ext) begin
      case (code)
        SC_RIGHT_E: res = 3'b111;
        SC_LEFT_E:  res = 3'b110;
        SC_FWD_E:   res = 3'b101;
        SC_BACK_E:  res = 3'b100;
        default:    res = 3'b000;
      endcase
    end else begin
      case (code)
        SC_RIGHT: res = 3'b111;
        SC_LEFT:  res = 3'b110;
        SC_FWD:   res = 3'b101;
        SC_BACK:  res = 3'b100;
        default:  res = 3'b000;
      endcase
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_movement_decoder_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_rx: sync, glitch filter, frame receiver with timeout          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ps2_rx
  import ps2_movement_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_byte_valid,
  output logic [7:0] o_scan_code,
  output logic       o_frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  rx_state_t     r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_par;
  logic [TW-1:0] r_tcnt;

  logic w_flip;
  logic w_strobe;
  logic w_dat;
  logic w_timeout;

  assign w_flip    = (r_clk_s[1] != r_filt) && (r_fcnt == FW'(FILTER_LEN - 1));
  assign w_strobe  = w_flip && r_filt;
  assign w_dat     = r_dat_s[1];
  assign w_timeout = (r_state != RX_IDLE) && !w_strobe && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_filt  <= 1'b1;
      r_fcnt  <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_dat};
      if (r_clk_s[1] == r_filt) begin
        r_fcnt <= '0;
      end else if (w_flip) begin
        r_filt <= r_clk_s[1];
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= RX_IDLE;
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_par         <= 1'b0;
      r_tcnt        <= '0;
      o_byte_valid  <= 1'b0;
      o_scan_code   <= 8'h00;
      o_frame_error <= 1'b0;
    end else begin
      o_byte_valid  <= 1'b0;
      o_frame_error <= 1'b0;
      if (r_state == RX_IDLE || w_strobe) r_tcnt <= '0;
      else                                r_tcnt <= r_tcnt + 1'b1;

      case (r_state)
        RX_IDLE: begin
          if (w_strobe && !w_dat) begin
            r_state  <= RX_DATA;
            r_bitcnt <= '0;
          end
        end
        RX_DATA: begin
          if (w_strobe) begin
            r_shift  <= {w_dat, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= RX_PARITY;
          end
        end
        RX_PARITY: begin
          if (w_strobe) begin
            r_par   <= w_dat;
            r_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (w_strobe) begin
            if ((^{r_shift, r_par}) && w_dat) begin
              o_byte_valid <= 1'b1;
              o_scan_code  <= r_shift;
            end else begin
              o_frame_error <= 1'b1;
            end
            r_state <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase

      // A stalled keyboard must not leave a half-received frame pending.
      if (w_timeout) begin
        r_state       <= RX_IDLE;
        o_frame_error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_movement_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_movement_decoder: PS/2 make/break decode to four held flags   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ps2_movement_decoder
  import ps2_movement_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       turn_right,
  output logic       turn_left,
  output logic       move_forward,
  output logic       move_backward,
  output logic       byte_valid,
  output logic [7:0] scan_code,
  output logic       frame_error
);

  logic       w_bv;
  logic       w_fe;
  logic [7:0] w_code;
  logic [2:0] w_hit;
  logic [3:0] r_keys;
  logic       r_ext;
  logic       r_brk;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .i_ps2_clk     (ps2_clk),
    .i_ps2_dat     (ps2_dat),
    .o_byte_valid  (w_bv),
    .o_scan_code   (w_code),
    .o_frame_error (w_fe)
  );

  assign w_hit = key_lookup(r_ext, w_code);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_keys <= 4'b0000;
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
    end else if (w_fe) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_bv) begin
      if (w_code == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (w_code == SC_BRK) begin
        r_brk <= 1'b1;
      end else if (w_code == SC_OVR0 || w_code == SC_OVR1) begin
        r_keys <= 4'b0000;
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
      end else begin
        if (w_hit[2]) r_keys[w_hit[1:0]] <= !r_brk;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign turn_right    = r_keys[3];
  assign turn_left     = r_keys[2];
  assign move_forward  = r_keys[1];
  assign move_backward = r_keys[0];
  assign byte_valid    = w_bv;
  assign scan_code     = w_code;
  assign frame_error   = w_fe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_movement_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ps2_movement_decoder: scoreboard bench with key-state model    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_ps2_movement_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;

  logic       clock;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       turn_right, turn_left, move_forward, move_backward;
  logic       byte_valid;
  logic [7:0] scan_code;
  logic       frame_error;
  logic [3:0] flags;

  assign flags = {turn_right, turn_left, move_forward, move_backward};

  ps2_movement_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_dat       (ps2_dat),
    .turn_right    (turn_right),
    .turn_left     (turn_left),
    .move_forward  (move_forward),
    .move_backward (move_backward),
    .byte_valid    (byte_valid),
    .scan_code     (scan_code),
    .frame_error   (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic [3:0] flags;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: key held state, prefix state, last good byte.
  int         keymap[bit [8:0]];
  logic [3:0] m_keys;
  bit         m_ext, m_brk;
  logic [7:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_keys = 4'b0000;
    m_ext  = 0;
    m_brk  = 0;
    m_last = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    exp_t e;
    if (bad) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      m_last = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'h00 || b == 8'hFF) begin
        m_keys = 4'b0000;
        m_ext  = 0;
        m_brk  = 0;
      end else begin
        if (keymap.exists({m_ext, b})) m_keys[keymap[{m_ext, b}]] = !m_brk;
        m_ext = 0;
        m_brk = 0;
      end
    end
    e.err   = bad;
    e.code  = m_last;
    e.flags = m_keys;
    q.push_back(e);
  endtask

  task automatic ps2_bit(input bit b, input int hb);
    ps2_dat = b;
    repeat (hb) @(posedge clock);
    #1 ps2_clk = 1'b0;
    repeat (hb) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    int hb;
    hb = $urandom_range(14, 30);
    ps2_bit(1'b0, hb);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], hb);
    ps2_bit(bad_par ? ^b : ~^b, hb);
    model_byte(b, bad_par);
    ps2_bit(1'b1, hb);
    ps2_dat = 1'b1;
    repeat (3 * hb) @(posedge clock);
  endtask

  // Monitor: pops one expectation per output pulse.
  initial begin
    exp_t       e;
    logic [3:0] prev;
    prev = 4'b0000;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev = 4'b0000;
      end else if (byte_valid || frame_error) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pulse: got bv=%0b fe=%0b expected none at %0t",
                   byte_valid, frame_error, $time);
        end else begin
          e = q.pop_front();
          check("pulse_kind", {30'd0, byte_valid, frame_error}, e.err ? 32'd1 : 32'd2);
          check("scan_code", {24'd0, scan_code}, {24'd0, e.code});
          check("flags_before", {28'd0, flags}, {28'd0, prev});
          @(negedge clock);
          check("flags_after", {28'd0, flags}, {28'd0, e.flags});
          check("pulse_width", {30'd0, byte_valid, frame_error}, 32'd0);
          prev = e.flags;
        end
      end
    end
  end

  initial begin
    logic [7:0] pool[14];
    logic [7:0] b;
    keymap[{1'b1, 8'h74}] = 3;
    keymap[{1'b1, 8'h6B}] = 2;
    keymap[{1'b1, 8'h75}] = 1;
    keymap[{1'b1, 8'h72}] = 0;
    keymap[{1'b0, 8'h23}] = 3;
    keymap[{1'b0, 8'h1C}] = 2;
    keymap[{1'b0, 8'h1D}] = 1;
    keymap[{1'b0, 8'h1B}] = 0;
    pool = '{8'hE0, 8'hF0, 8'h74, 8'h6B, 8'h75, 8'h72, 8'h23,
             8'h1C, 8'h1D, 8'h1B, 8'hE0, 8'hF0, 8'h00, 8'h5A};
    model_reset();

    reset   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("reset_flags", {28'd0, flags}, 32'd0);
    check("reset_code", {24'd0, scan_code}, 32'd0);
    check("reset_pulses", {30'd0, byte_valid, frame_error}, 32'd0);
    reset = 1'b1;
    repeat (20) @(posedge clock);

    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);

    send_frame(8'h1D, 0); send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    send_frame(8'hF0, 0); send_frame(8'h1D, 0);

    send_frame(8'h74, 1);
    send_frame(8'hE0, 0); send_frame(8'h74, 0);

    begin
      int hb;
      hb = 20;
      ps2_bit(1'b0, hb);
      for (int i = 0; i < 4; i++) ps2_bit(i[0], hb);
      model_byte(8'h00, 1);
      ps2_dat = 1'b1;
      repeat (TIMEOUT_CYCLES + 10) @(posedge clock);
    end
    send_frame(8'h1B, 0);

    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h74, 0);
    #1 ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(posedge clock);
    #1 ps2_clk = 1'b1;
    repeat (40) @(posedge clock);
    send_frame(8'h74, 0);

    send_frame(8'hE0, 0); send_frame(8'h72, 0);
    send_frame(8'hFF, 0);

    send_frame(8'h23, 0);
    ps2_bit(1'b0, 20);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 20);
    #3 reset = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    #1;
    check("midreset_flags", {28'd0, flags}, 32'd0);
    check("midreset_code", {24'd0, scan_code}, 32'd0);
    check("midreset_pulses", {30'd0, byte_valid, frame_error}, 32'd0);
    model_reset();
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    repeat (200) @(posedge clock);
    send_frame(8'h1C, 0);

    for (int n = 0; n < 30; n++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      send_frame(b, $urandom_range(0, 7) == 0);
    end

    for (int w = 0; w < 3000 && q.size() != 0; w++) @(posedge clock);
    check("queue_drained", q.size(), 32'd0);
    repeat (20) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
